// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
// No logic of its own; imported by every serial_subtractor file.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to count WIDTH processed bit positions (0 .. WIDTH-1).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle between a requester (master) and the serial subtractor (slave).
// Carries start/a/b towards the subtractor and busy/done/diff/bout (and ovf) back.
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bo = borrow out.
// Latency: purely combinational.
// Backpressure: none; used as the bit slice of the serial datapath.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    // Borrow when x=0,y=1, or when the bits are equal and a borrow arrives.
    assign bo   = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor diff = a - b, LSB first, registered borrow; optional ovf via SERIAL_SUB_OVF_EN.
// Latency: WIDTH shift edges after the accepting edge, then a one-cycle done pulse (WIDTH+2 cycles per operation).
// Backpressure: start is sampled only in IDLE; starts during SHIFT or DONE are dropped, never queued.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_ovf;
`endif

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_next;

    full_subtractor u_fs (
        .x   (r_a_sh[0]),
        .y   (r_b_sh[0]),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_bo)
    );

    // New result bit enters at the MSB so that after WIDTH shifts the first bit sits at bit 0.
    assign w_diff_next = {w_d, r_diff_sh[WIDTH-1:1]};

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_diff    <= '0;
            r_cnt     <= '0;
            r_borrow  <= 1'b0;
            r_bout    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb   <= 1'b0;
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a_sh    <= bus.a;
                        r_b_sh    <= bus.b;
                        r_diff_sh <= '0;
                        r_cnt     <= '0;
                        r_borrow  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb   <= bus.a[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_diff_sh <= w_diff_next;
                    r_borrow  <= w_bo;
                    r_cnt     <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_diff  <= w_diff_next;
                        r_bout  <= w_bo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit, r_b_sh[0] is b's MSB and w_d is diff's MSB.
                        r_ovf   <= (r_a_msb != r_b_sh[0]) & (w_d != r_a_msb);
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): table vectors, random operands, corner sequences.
// Expected results come from plain integer arithmetic on the operands.
// ovf is checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) bif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer subtraction, unsigned compare, signed range test.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t r;
        int sa, sb, sd;
        r.a  = a;
        r.b  = b;
        r.d  = W'((int'(a) - int'(b)) & ((1 << W) - 1));
        r.bo = (int'(a) < int'(b));
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd = sa - sb;
        r.ov = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
        return r;
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return bif.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // One operation over a fixed window; optionally injects a start at busy
    // cycle spur_busy (0 = never) and/or in the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int spur_busy, input bit spur_done,
                          output int busy_n, output int done_n, output int done_edge,
                          output logic [W-1:0] rd, output logic rb, output logic ro);
        @(negedge clk);
        bif.a     = ta;
        bif.b     = tb_v;
        bif.start = 1'b1;
        @(posedge clk);
        busy_n = 0; done_n = 0; done_edge = -1; rd = '0; rb = 1'b0; ro = 1'b0;
        for (int e = 1; e <= W + 6; e++) begin
            if (e > 1) @(posedge clk);
            @(negedge clk);
            bif.start = 1'b0;
            bif.a     = W'($urandom);
            bif.b     = W'($urandom);
            if (bif.busy) busy_n++;
            if (bif.done) begin
                done_n++;
                if (done_edge < 0) begin
                    done_edge = e;
                    rd = bif.diff;
                    rb = bif.bout;
                    ro = get_ovf();
                end
            end
            if (spur_busy != 0 && bif.busy && busy_n == spur_busy) bif.start = 1'b1;
            if (spur_done && bif.done) bif.start = 1'b1;
        end
        bif.start = 1'b0;
    endtask

    task automatic check_op(input string tag, input vec_t exp,
                            input int spur_busy, input bit spur_done);
        int bn, dn, de;
        logic [W-1:0] rd;
        logic rb, ro;
        run_op(exp.a, exp.b, spur_busy, spur_done, bn, dn, de, rd, rb, ro);
        chk({tag, "_diff"}, 32'(rd), 32'(exp.d));
        chk({tag, "_bout"}, 32'(rb), 32'(exp.bo));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ro), 32'(exp.ov));
`endif
        chk({tag, "_done_cnt"}, 32'(dn), 32'd1);
        chk({tag, "_latency"}, 32'(de), 32'(W + 1));
        chk({tag, "_busy_cnt"}, 32'(bn), 32'(W));
        chk({tag, "_diff_hold"}, 32'(bif.diff), 32'(exp.d));
        chk({tag, "_bout_hold"}, 32'(bif.bout), 32'(exp.bo));
    endtask

    initial begin
        int dn;
        vec_t v;

        tbl[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        tbl[3] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        tbl[4] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, bo: 1'b0, ov: 1'b0};
        tbl[5] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
        tbl[6] = '{a: 8'h00, b: 8'h80, d: 8'h80, bo: 1'b1, ov: 1'b1};
        tbl[7] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bo: 1'b0, ov: 1'b0};

        rst = 1'b1;
        bif.start = 1'b0;
        bif.a = '0;
        bif.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_diff", 32'(bif.diff), 32'd0);
        chk("rst_bout", 32'(bif.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(bif.ovf), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i], 0, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            v = model(W'($urandom), W'($urandom));
            check_op($sformatf("rnd%0d", i), v, 0, 1'b0);
        end

        // Starts during SHIFT (busy cycle 3) and during DONE must be dropped.
        check_op("spur", model(8'h30, 8'h11), 3, 1'b1);
        @(negedge clk);
        chk("spur_idle_busy", 32'(bif.busy), 32'd0);

        // Reset in busy cycle 4 aborts the operation without a done pulse.
        @(negedge clk);
        bif.a = 8'hC3;
        bif.b = 8'h21;
        bif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", 32'(bif.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bif.busy), 32'd0);
        chk("abort_done", 32'(bif.done), 32'd0);
        chk("abort_diff", 32'(bif.diff), 32'd0);
        chk("abort_bout", 32'(bif.bout), 32'd0);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bif.done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);

        check_op("after_abort", model(8'h09, 8'h04), 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
